fft_peak_picker: RTL and testbench
==================================

Name: fft_peak_picker

Overview:
- Downstream consumer of the per-channel FFT wrapper. Waits for the wrapper's result-ready flag, then sweeps the FFT result RAM over a configurable bin window.
- Computes |X|^2 = re^2 + im^2 per bin. Reports the peak bin, its power and the window's total power to the localisation logic.
- After the result is acknowledged, pulses go back to the wrapper to re-arm the next frame.

Parameters:
- N_PTS, 1024, FFT length; sets address width AW = clog2(N_PTS) = 10.
- BIN_LO, 1, first bin scanned (skips DC).
- BIN_HI, 511, last bin scanned, inclusive (positive-frequency half). Requires BIN_LO <= BIN_HI < N_PTS.
- RD_LAT, 2, result-RAM read latency in cycles (address to q).
- DW, 14, width of each real/imag component.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- fft_ready  in  1  wrapper out_ready; level, high while the FFT RAM holds a complete frame.
- rd_addr_fft  out  AW  read address into the FFT result RAM.
- ram_q  in  2*DW  RAM data: [2DW-1:DW] = real, [DW-1:0] = imag, both two's complement.
- go  out  1  one-cycle pulse to the wrapper: frame consumed, restart.
- busy  out  1  high from scan start until go is issued.
- result_valid  out  1  peak outputs valid; held until result_ack.
- result_ack  in  1  consumer accepts the result.
- peak_bin  out  AW  index of maximum |X|^2.
- peak_pow  out  2*DW  maximum |X|^2, unsigned.
- sum_pow  out  2*DW+AW  sum of |X|^2 over BIN_LO..BIN_HI, unsigned.

Behaviour:
- Reset values (asynchronous): state=IDLE, rd_addr_fft=BIN_LO, go=0, busy=0, result_valid=0, peak_bin=0, peak_pow=0, sum_pow=0; pipeline valid bits cleared.
- FSM states: IDLE, SCAN, DRAIN, HOLD, RELEASE, REARM.
- IDLE:
  - rd_addr_fft=BIN_LO.
  - On fft_ready=1: go to SCAN, set busy=1, clear the running max, max index and accumulator.
- SCAN:
  - Issue one address per cycle, BIN_LO..BIN_HI, no stalls.
  - The cycle issuing BIN_HI moves to DRAIN.
  - A valid token and its address travel down a shift line of length RD_LAT, aligned with ram_q.
- Datapath (pipelined, one bin per cycle):
  - P1: register re^2 and im^2, each signed DW x DW product kept as 2DW-1 bits unsigned.
  - P2: register pow = re^2 + im^2 in 2DW bits. Worst case (-2^(DW-1))^2 * 2 = 2^(2DW-1), so it fits without overflow.
  - P3: if pow > running max (strict), update max and index. Ties keep the lower bin. Add pow to the accumulator (2DW+AW bits, cannot overflow).
- Total latency, first address to result_valid: (BIN_HI-BIN_LO+1) + RD_LAT + 3 cycles.
- DRAIN: wait until all pipeline valid bits are 0. Then load peak_bin, peak_pow and sum_pow, set result_valid=1, go to HOLD.
- HOLD:
  - Outputs are stable while result_valid=1.
  - On result_ack=1: result_valid=0 next cycle, go to RELEASE.
  - A result_ack seen in the same cycle result_valid rises counts.
  - result_ack outside HOLD is ignored.
- RELEASE: go=1 for exactly one cycle; busy=0; go to REARM.
- REARM:
  - Wait for fft_ready=0 (the wrapper clears out_ready two cycles after go), then go to IDLE.
  - Prevents re-scanning the stale frame.
- fft_ready dropping during SCAN/DRAIN: the scan completes anyway and the result is still reported. The wrapper only clears fft_ready after go, so this is a protocol error, not a supported case.
- Reset mid-scan: all state is discarded immediately; no go pulse is emitted.
- Degenerate window BIN_LO == BIN_HI: one-cycle SCAN; peak_bin=BIN_LO; peak_pow = sum_pow = that bin's power.
- All-zero frame: peak_pow=0, peak_bin=BIN_LO, sum_pow=0.

Decomposition:
- Shared package fft_pkg, holding:
  - FFT_PTS=1024, FFT_AW=10, FFT_DW=14.
  - typedef fft_bin_t (packed struct: real, imag, signed DW each), matching the RAM word layout.
  - typedef pow_t (2DW unsigned).
  - FSM enum peak_state_t.
- One sub-module: fft_bin_power. Takes a bin, produces pow with 2-cycle latency (P1/P2), with valid and index pass-through.
- Compare/accumulate and FSM stay in the top.

Test Plan:
- Single tone: RAM model with bin 37 = (1000, -500), all other bins (3, 4); fft_ready=1 -> peak_bin=37, peak_pow=1250000, sum_pow = 1250000 + 510*25 = 1262750, result_valid after 511+RD_LAT+3 cycles.
- Tie: bins 100 and 200 both (2000, 0), others 0 -> peak_bin=100, peak_pow=4000000.
- Extremes: bin 511 = (-8192, -8192), others (-8192, 0) -> peak_bin=511, peak_pow=134217728, no overflow in sum_pow.
- Handshake: hold result_ack=0 for 50 cycles -> outputs stable, go stays 0. Pulse ack -> go exactly one cycle later, one cycle wide. fft_ready kept high 2 cycles after go -> no second scan. Next fft_ready rise -> new scan.
- Window bounds: DC bin 0 = (8000, 8000), bin 600 = (8000, 0) -> neither selected; addresses observed only in 1..511.
- Reset mid-SCAN at address 300 -> all outputs at reset values next cycle, no go pulse. A following fft_ready=1 restarts the scan from BIN_LO.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT result consumers: RAM word layout, power type and
// the peak-picker state encoding.
package fft_pkg;

   localparam int FFT_PTS = 1024;
   localparam int FFT_AW  = $clog2(FFT_PTS);
   localparam int FFT_DW  = 14;

   // Field order matches the RAM word: real in the upper half, imag in the lower.
   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } fft_bin_t;

   typedef logic [2*FFT_DW-1:0] pow_t;

   typedef enum logic [2:0] {
      PK_IDLE,
      PK_SCAN,
      PK_DRAIN,
      PK_HOLD,
      PK_RELEASE,
      PK_REARM
   } peak_state_t;

endpackage

// File: rtl/fft_bin_power.sv
// Two-stage |X|^2 pipeline: squares of both components, then their sum.
// Valid and bin index ride alongside the data.
module fft_bin_power
   import fft_pkg::*;
#(
   parameter int AW = FFT_AW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [AW-1:0] i_idx,
   input  fft_bin_t      i_bin,
   output logic          o_valid,
   output logic [AW-1:0] o_idx,
   output pow_t          o_pow,
   output logic          o_busy
);

   // A square of a DW-bit signed value never exceeds 2^(2DW-2), so 2DW-1 bits hold it.
   localparam int SQ_W = 2*FFT_DW-1;

   logic            r_v1;
   logic            r_v2;
   logic [AW-1:0]   r_idx1;
   logic [AW-1:0]   r_idx2;
   logic [SQ_W-1:0] r_re_sq;
   logic [SQ_W-1:0] r_im_sq;
   pow_t            r_pow;

   // NOTE: sequential state uses <= so every stage samples its neighbour's previous value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         r_v1 <= i_valid;
         r_v2 <= r_v1;
      end
   end

   // NOTE: data lanes carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      r_idx1  <= i_idx;
      r_re_sq <= SQ_W'(i_bin.re * i_bin.re);
      r_im_sq <= SQ_W'(i_bin.im * i_bin.im);
      r_idx2  <= r_idx1;
      r_pow   <= pow_t'(r_re_sq) + pow_t'(r_im_sq);
   end

   assign o_valid = r_v2;
   assign o_idx   = r_idx2;
   assign o_pow   = r_pow;
   assign o_busy  = r_v1 | r_v2;

endmodule

// File: rtl/fft_peak_picker.sv
// Sweeps the FFT result RAM over a bin window, reports the strongest bin, its
// power and the window's total power, then re-arms the FFT wrapper.
module fft_peak_picker
   import fft_pkg::*;
#(
   parameter int N_PTS  = FFT_PTS,
   parameter int BIN_LO = 1,
   parameter int BIN_HI = 511,
   parameter int RD_LAT = 2,
   parameter int DW     = FFT_DW,
   localparam int AW    = $clog2(N_PTS)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fft_ready,
   output logic [AW-1:0]        rd_addr_fft,
   input  logic [2*DW-1:0]      ram_q,
   output logic                 go,
   output logic                 busy,
   output logic                 result_valid,
   input  logic                 result_ack,
   output logic [AW-1:0]        peak_bin,
   output logic [2*DW-1:0]      peak_pow,
   output logic [2*DW+AW-1:0]   sum_pow
);

   localparam int            ACC_W = 2*DW+AW;
   localparam logic [AW-1:0] LO_A  = AW'(BIN_LO);
   localparam logic [AW-1:0] HI_A  = AW'(BIN_HI);

   peak_state_t        r_state;
   logic [AW-1:0]      r_addr;
   logic               r_go;
   logic               r_busy;
   logic               r_result_valid;
   logic [AW-1:0]      r_peak_bin;
   pow_t               r_peak_pow;
   logic [ACC_W-1:0]   r_sum_pow;

   logic [RD_LAT-1:0]  r_sr_vld;
   logic [AW-1:0]      r_sr_addr [RD_LAT];

   pow_t               r_max_pow;
   logic [AW-1:0]      r_max_idx;
   logic [ACC_W-1:0]   r_acc;

   logic               w_issue;
   logic               w_start;
   fft_bin_t           w_bin;
   logic               w_pw_valid;
   logic [AW-1:0]      w_pw_idx;
   pow_t               w_pw_pow;
   logic               w_pw_busy;
   logic               w_pipe_busy;

   assign w_issue     = (r_state == PK_SCAN);
   assign w_start     = (r_state == PK_IDLE) && fft_ready;
   assign w_bin       = ram_q;
   assign w_pipe_busy = (|r_sr_vld) | w_pw_busy;

   // Token/address line that lines each issued address up with its ram_q word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr_vld <= '0;
      end else begin
         r_sr_vld[0] <= w_issue;
         for (int i = 1; i < RD_LAT; i++) r_sr_vld[i] <= r_sr_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_sr_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) r_sr_addr[i] <= r_sr_addr[i-1];
   end

   fft_bin_power #(.AW(AW)) u_bin_power (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_sr_vld[RD_LAT-1]),
      .i_idx   (r_sr_addr[RD_LAT-1]),
      .i_bin   (w_bin),
      .o_valid (w_pw_valid),
      .o_idx   (w_pw_idx),
      .o_pow   (w_pw_pow),
      .o_busy  (w_pw_busy)
   );

   // Strict compare keeps the lowest bin on ties; an all-zero window leaves BIN_LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max_pow <= '0;
         r_max_idx <= LO_A;
         r_acc     <= '0;
      end else if (w_start) begin
         r_max_pow <= '0;
         r_max_idx <= LO_A;
         r_acc     <= '0;
      end else if (w_pw_valid) begin
         if (w_pw_pow > r_max_pow) begin
            r_max_pow <= w_pw_pow;
            r_max_idx <= w_pw_idx;
         end
         r_acc <= r_acc + ACC_W'(w_pw_pow);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= PK_IDLE;
         r_addr         <= LO_A;
         r_go           <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_peak_bin     <= '0;
         r_peak_pow     <= '0;
         r_sum_pow      <= '0;
      end else begin
         r_go <= 1'b0;
         case (r_state)
            PK_IDLE: begin
               r_addr <= LO_A;
               if (fft_ready) begin
                  r_state <= PK_SCAN;
                  r_busy  <= 1'b1;
               end
            end
            PK_SCAN: begin
               if (r_addr == HI_A) r_state <= PK_DRAIN;
               else                r_addr  <= r_addr + AW'(1);
            end
            PK_DRAIN: begin
               if (!w_pipe_busy) begin
                  r_peak_bin     <= r_max_idx;
                  r_peak_pow     <= r_max_pow;
                  r_sum_pow      <= r_acc;
                  r_result_valid <= 1'b1;
                  r_state        <= PK_HOLD;
               end
            end
            PK_HOLD: begin
               // go is launched with the ack so it lands exactly one cycle after it.
               if (result_ack) begin
                  r_result_valid <= 1'b0;
                  r_go           <= 1'b1;
                  r_busy         <= 1'b0;
                  r_state        <= PK_RELEASE;
               end
            end
            PK_RELEASE: begin
               r_state <= PK_REARM;
            end
            PK_REARM: begin
               if (!fft_ready) r_state <= PK_IDLE;
            end
            default: r_state <= PK_IDLE;
         endcase
      end
   end

   assign rd_addr_fft  = r_addr;
   assign go           = r_go;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign peak_bin     = r_peak_bin;
   assign peak_pow     = r_peak_pow;
   assign sum_pow      = r_sum_pow;

endmodule

// File: tb/tb_fft_peak_picker.sv
// Randomised scoreboard bench for fft_peak_picker with a behavioural result RAM
// and a window-level reference model of the peak/sum computation.
module tb_fft_peak_picker;
   import fft_pkg::*;

   localparam int BIN_LO = 1;
   localparam int BIN_HI = 511;
   localparam int RD_LAT = 2;
   localparam int AW     = 10;
   localparam int DW     = 14;
   localparam int LAT    = (BIN_HI - BIN_LO + 1) + RD_LAT + 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                fft_ready;
   logic                result_ack;
   logic [AW-1:0]       rd_addr_fft;
   logic [2*DW-1:0]     ram_q;
   logic                go;
   logic                busy;
   logic                result_valid;
   logic [AW-1:0]       peak_bin;
   logic [2*DW-1:0]     peak_pow;
   logic [2*DW+AW-1:0]  sum_pow;

   fft_peak_picker #(
      .N_PTS(1024), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI), .RD_LAT(RD_LAT), .DW(DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fft_ready    (fft_ready),
      .rd_addr_fft  (rd_addr_fft),
      .ram_q        (ram_q),
      .go           (go),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .peak_bin     (peak_bin),
      .peak_pow     (peak_pow),
      .sum_pow      (sum_pow)
   );

   always #5 clk = ~clk;

   // Result RAM: two-cycle read latency, address to q.
   logic signed [DW-1:0] mem_re [1024];
   logic signed [DW-1:0] mem_im [1024];
   logic [AW-1:0]        ram_a1;
   always @(posedge clk) begin
      ram_a1 <= rd_addr_fft;
      ram_q  <= {mem_re[ram_a1], mem_im[ram_a1]};
   end

   typedef struct {
      longint unsigned bin;
      longint unsigned pow;
      longint unsigned sum;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   frames_done = 0;
   int   go_count = 0;
   int   oob_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic over the window, strict max so ties keep the lower bin.
   function automatic exp_t model();
      exp_t e;
      e.bin = BIN_LO;
      e.pow = 0;
      e.sum = 0;
      for (int b = BIN_LO; b <= BIN_HI; b++) begin
         longint r;
         longint i;
         longint unsigned p;
         r = longint'(mem_re[b]);
         i = longint'(mem_im[b]);
         p = longint'(r*r + i*i);
         if (p > e.pow) begin
            e.pow = p;
            e.bin = longint'(b);
         end
         e.sum += p;
      end
      return e;
   endfunction

   task automatic fill(input int re, input int im);
      for (int b = 0; b < 1024; b++) begin
         mem_re[b] = DW'(re);
         mem_im[b] = DW'(im);
      end
   endtask

   task automatic fill_random(input int span);
      for (int b = 0; b < 1024; b++) begin
         if (span == 0) begin
            mem_re[b] = DW'($urandom);
            mem_im[b] = DW'($urandom);
         end else begin
            mem_re[b] = DW'(int'($urandom_range(0, 2*span)) - span);
            mem_im[b] = DW'(int'($urandom_range(0, 2*span)) - span);
         end
      end
   endtask

   // Monitor: scan-start address, address window, go pulses, result scoreboard, latency.
   logic rv_prev;
   logic busy_prev;
   int   ncyc = 0;
   int   busy_rise_cyc = -1;
   exp_t mon_e;
   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         rv_prev       = 1'b0;
         busy_prev     = 1'b0;
         busy_rise_cyc = -1;
      end else begin
         if (busy && !busy_prev) begin
            busy_rise_cyc = ncyc;
            check("scan_start_addr", 64'(rd_addr_fft), 64'(BIN_LO));
         end
         if (int'(rd_addr_fft) < BIN_LO || int'(rd_addr_fft) > BIN_HI) oob_count++;
         if (go) go_count++;
         if (result_valid && !rv_prev) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got bin %0d with empty scoreboard", peak_bin);
            end else begin
               mon_e = sb_q.pop_front();
               check("peak_bin", 64'(peak_bin), mon_e.bin);
               check("peak_pow", 64'(peak_pow), mon_e.pow);
               check("sum_pow",  64'(sum_pow),  mon_e.sum);
               check("latency",  64'(ncyc - busy_rise_cyc), 64'(LAT));
            end
         end
         rv_prev   = result_valid;
         busy_prev = busy;
      end
   end

   task automatic check_reset_values(input string nm);
      check({nm, "_addr"},  64'(rd_addr_fft),  64'(BIN_LO));
      check({nm, "_go"},    64'(go),           64'd0);
      check({nm, "_busy"},  64'(busy),         64'd0);
      check({nm, "_valid"}, 64'(result_valid), 64'd0);
      check({nm, "_bin"},   64'(peak_bin),     64'd0);
      check({nm, "_pow"},   64'(peak_pow),     64'd0);
      check({nm, "_sum"},   64'(sum_pow),      64'd0);
   endtask

   task automatic run_frame(input string nm, input int hold_cyc, input bit early_ack);
      exp_t e;
      int   k;
      int   bad;
      e = model();
      sb_q.push_back(e);
      fft_ready = 1'b1;
      if (early_ack) begin
         repeat (100) @(negedge clk);
         result_ack = 1'b1;
         @(negedge clk);
         result_ack = 1'b0;
      end
      k = 0;
      while (!result_valid && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (!result_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got no result_valid, expected one within %0d cycles", nm, LAT);
         fft_ready = 1'b0;
         return;
      end
      bad = 0;
      for (int i = 0; i < hold_cyc; i++) begin
         @(negedge clk);
         if (result_valid !== 1'b1 || go !== 1'b0 || 64'(peak_bin) !== e.bin ||
             64'(peak_pow) !== e.pow || 64'(sum_pow) !== e.sum) bad++;
      end
      if (hold_cyc > 0) check({nm, "_hold_stable"}, 64'(bad), 64'd0);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      check({nm, "_go_after_ack"},    64'(go),           64'd1);
      check({nm, "_valid_after_ack"}, 64'(result_valid), 64'd0);
      check({nm, "_busy_after_ack"},  64'(busy),         64'd0);
      @(negedge clk);
      check({nm, "_go_one_cycle"},    64'(go),           64'd0);
      frames_done++;
      @(negedge clk);
      fft_ready = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0) bad++;
      end
      check({nm, "_no_rescan"}, 64'(bad), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected end within 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst        = 1'b1;
      fft_ready  = 1'b0;
      result_ack = 1'b0;
      fill(0, 0);
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);

      // Single tone over a small noise floor; ack withheld for 50 cycles.
      fill(3, 4);
      mem_re[37] = DW'(1000);
      mem_im[37] = DW'(-500);
      run_frame("tone", 50, 1'b0);

      // Equal peaks: the lower bin wins.
      fill(0, 0);
      mem_re[100] = DW'(2000);
      mem_re[200] = DW'(2000);
      run_frame("tie", 0, 1'b0);

      // Most negative components everywhere, the corner at the top bin.
      fill(-8192, 0);
      mem_im[511] = DW'(-8192);
      run_frame("extremes", 0, 1'b0);

      // Large bins just outside the window must not be picked.
      fill_random(64);
      mem_re[0]   = DW'(8000);
      mem_im[0]   = DW'(8000);
      mem_re[600] = DW'(8000);
      mem_im[600] = DW'(0);
      run_frame("window", 0, 1'b0);

      fill(0, 0);
      run_frame("zero", 0, 1'b0);

      fill_random(0);
      run_frame("rand_early_ack", 5, 1'b1);
      fill_random(0);
      run_frame("rand_a", 0, 1'b0);
      fill_random(300);
      run_frame("rand_b", 3, 1'b0);

      // Reset in the middle of a scan, then restart from BIN_LO.
      fill_random(0);
      fft_ready = 1'b1;
      k = 0;
      while (rd_addr_fft !== AW'(300) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("midscan_reached_300", 64'(rd_addr_fft), 64'd300);
      rst = 1'b1;
      #1;
      check_reset_values("midscan_reset");
      @(negedge clk);
      rst = 1'b0;
      run_frame("post_reset", 0, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      check("go_pulse_count",   64'(go_count),    64'(frames_done));
      check("addr_window",      64'(oob_count),   64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
